// File: rtl/toysram_rf_pkg.sv
// Shared types and sizes for the 64x24 2R1W toysram register-file port controller.
package toysram_rf_pkg;

   localparam int RF_ADR_W = 6;
   localparam int RF_DAT_W = 24;

   // Field order is the array pin order; the parent unpacks it with one concatenation.
   typedef struct packed {
      logic c_na0;
      logic c_a0;
      logic na1_na2;
      logic na1_a2;
      logic a1_na2;
      logic a1_a2;
      logic na3;
      logic a3;
      logic na4_na5;
      logic na4_a5;
      logic a4_na5;
      logic a4_a5;
   } rf_predec_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD
   } wr_state_t;

endpackage

// File: rtl/toysram_rf_predec.sv
// Combinational address predecoder: binary address plus enable to the 12 array lines.
module toysram_rf_predec
   import toysram_rf_pkg::*;
(
   input  logic [0:RF_ADR_W-1] adr,
   input  logic                en,
   output rf_predec_t          pd
);

   assign pd.c_na0   = en & ~adr[0];
   assign pd.c_a0    = en &  adr[0];
   assign pd.na1_na2 = en & ~adr[1] & ~adr[2];
   assign pd.na1_a2  = en & ~adr[1] &  adr[2];
   assign pd.a1_na2  = en &  adr[1] & ~adr[2];
   assign pd.a1_a2   = en &  adr[1] &  adr[2];
   assign pd.na3     = en & ~adr[3];
   assign pd.a3      = en &  adr[3];
   assign pd.na4_na5 = en & ~adr[4] & ~adr[5];
   assign pd.na4_a5  = en & ~adr[4] &  adr[5];
   assign pd.a4_na5  = en &  adr[4] & ~adr[5];
   assign pd.a4_a5   = en &  adr[4] &  adr[5];

endmodule

// File: rtl/regfile_64x24_2r1w_ctl.sv
// Port controller for the 64x24 2R1W toysram array: registered predecode, write
// pulse sequencing with setup/hold, registered read capture with write forwarding.
module regfile_64x24_2r1w_ctl
   import toysram_rf_pkg::*;
#(
   parameter int unsigned WR_PULSE = 2
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                rd0_req,
   input  logic [0:RF_ADR_W-1] rd0_adr,
   output logic                rd0_vld,
   output logic [0:RF_DAT_W-1] rd0_dat_q,
   input  logic                rd1_req,
   input  logic [0:RF_ADR_W-1] rd1_adr,
   output logic                rd1_vld,
   output logic [0:RF_DAT_W-1] rd1_dat_q,

   input  logic                wr0_req,
   input  logic [0:RF_ADR_W-1] wr0_adr,
   input  logic [0:RF_DAT_W-1] wr0_dat,
   output logic                wr0_rdy,
   output logic                wr0_done,

   output logic rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
   output logic rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5,
   output logic rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
   output logic rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5,
   output logic wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
   output logic wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5,

   output logic [0:RF_DAT_W-1] arr_wr0_dat,
   input  logic [0:RF_DAT_W-1] arr_rd0_dat,
   input  logic [0:RF_DAT_W-1] arr_rd1_dat
);

   wr_state_t                 state_q, state_d;
   logic [2:0]                cnt_q, cnt_d;
   logic [0:RF_ADR_W-1]       wr_adr_q, wr_adr_nxt;
   logic [0:RF_DAT_W-1]       wr_dat_q;
   logic                      wr_acc;
   rf_predec_t                wr_pd_raw, wr_pd_d, wr_pd_q;

   logic [1:0]                rd_req;
   logic [0:RF_ADR_W-1]       rd_adr   [2];
   logic [0:RF_DAT_W-1]       arr_rd   [2];
   rf_predec_t                rd_pd_d  [2];
   rf_predec_t                rd_pd_q  [2];
   logic [1:0]                rd_act_q, rd_vld_q, fwd;
   logic [0:RF_ADR_W-1]       rd_adr_q [2];
   logic [0:RF_DAT_W-1]       rd_dat_q [2];

   assign rd_req    = {rd1_req, rd0_req};
   assign rd_adr[0] = rd0_adr;
   assign rd_adr[1] = rd1_adr;
   assign arr_rd[0] = arr_rd0_dat;
   assign arr_rd[1] = arr_rd1_dat;

   assign wr0_rdy  = (state_q == S_IDLE) & ~rst;
   assign wr0_done = (state_q == S_HOLD);
   assign wr_acc   = wr0_req & wr0_rdy;

   // NOTE: every signal driven here gets its default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:  if (wr_acc) state_d = S_SETUP;
         S_SETUP: begin
            state_d = S_PULSE;
            cnt_d   = '0;
         end
         S_PULSE: begin
            if (cnt_q == 3'(WR_PULSE - 1)) state_d = S_HOLD;
            else                           cnt_d   = cnt_q + 3'd1;
         end
         S_HOLD:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Lines are registered, so they are decoded from the next-cycle address and state.
   assign wr_adr_nxt = wr_acc ? wr0_adr : wr_adr_q;

   toysram_rf_predec u_wr_predec (
      .adr (wr_adr_nxt),
      .en  (state_d != S_IDLE),
      .pd  (wr_pd_raw)
   );

   // Address lines span SETUP..HOLD; only the clock lines are confined to PULSE.
   always_comb begin
      wr_pd_d       = wr_pd_raw;
      wr_pd_d.c_na0 = wr_pd_raw.c_na0 & (state_d == S_PULSE);
      wr_pd_d.c_a0  = wr_pd_raw.c_a0  & (state_d == S_PULSE);
   end

   for (genvar p = 0; p < 2; p++) begin : g_rd_predec
      toysram_rf_predec u_rd_predec (
         .adr (rd_adr[p]),
         .en  (rd_req[p]),
         .pd  (rd_pd_d[p])
      );
   end

   always_comb begin
      fwd = '0;
      for (int p = 0; p < 2; p++)
         fwd[p] = (state_q != S_IDLE) && (rd_adr_q[p] == wr_adr_q);
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: datapath registers are reset too, because the array sees them as zeroed lines/data.
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wr_adr_q <= '0;
         wr_dat_q <= '0;
         wr_pd_q  <= '0;
         rd_act_q <= '0;
         rd_vld_q <= '0;
         for (int p = 0; p < 2; p++) begin
            rd_pd_q[p]  <= '0;
            rd_adr_q[p] <= '0;
            rd_dat_q[p] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_pd_q <= wr_pd_d;
         if (wr_acc) begin
            wr_adr_q <= wr0_adr;
            wr_dat_q <= wr0_dat;
         end
         rd_act_q <= rd_req;
         rd_vld_q <= rd_act_q;
         for (int p = 0; p < 2; p++) begin
            rd_pd_q[p]  <= rd_pd_d[p];
            rd_adr_q[p] <= rd_adr[p];
            if (rd_act_q[p]) rd_dat_q[p] <= fwd[p] ? wr_dat_q : arr_rd[p];
         end
      end
   end

   assign arr_wr0_dat = wr_dat_q;
   assign rd0_vld     = rd_vld_q[0];
   assign rd1_vld     = rd_vld_q[1];
   assign rd0_dat_q   = rd_dat_q[0];
   assign rd1_dat_q   = rd_dat_q[1];

   assign {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
           rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5} = rd_pd_q[0];
   assign {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
           rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5} = rd_pd_q[1];
   assign {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
           wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5} = wr_pd_q;

endmodule

// File: tb/tb_regfile_64x24_2r1w_ctl.sv
// Bench for regfile_64x24_2r1w_ctl: behavioural array, request-level reference model,
// per-cycle compare plus directed literal checks and a randomized phase.
module tb_regfile_64x24_2r1w_ctl;

   localparam int WR_PULSE = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd0_req = 1'b0, rd1_req = 1'b0, wr0_req = 1'b0;
   logic [0:5]  rd0_adr = '0, rd1_adr = '0, wr0_adr = '0;
   logic [0:23] wr0_dat = '0;
   logic        rd0_vld, rd1_vld, wr0_rdy, wr0_done;
   logic [0:23] rd0_dat_q, rd1_dat_q, arr_wr0_dat, arr_rd0_dat, arr_rd1_dat;
   logic rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2;
   logic rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5;
   logic rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2;
   logic rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5;
   logic wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2;
   logic wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5;

   always #5 clk = ~clk;

   regfile_64x24_2r1w_ctl #(.WR_PULSE(WR_PULSE)) dut (
      .clk(clk), .rst(rst),
      .rd0_req(rd0_req), .rd0_adr(rd0_adr), .rd0_vld(rd0_vld), .rd0_dat_q(rd0_dat_q),
      .rd1_req(rd1_req), .rd1_adr(rd1_adr), .rd1_vld(rd1_vld), .rd1_dat_q(rd1_dat_q),
      .wr0_req(wr0_req), .wr0_adr(wr0_adr), .wr0_dat(wr0_dat), .wr0_rdy(wr0_rdy), .wr0_done(wr0_done),
      .rd0_c_na0(rd0_c_na0), .rd0_c_a0(rd0_c_a0), .rd0_na1_na2(rd0_na1_na2), .rd0_na1_a2(rd0_na1_a2),
      .rd0_a1_na2(rd0_a1_na2), .rd0_a1_a2(rd0_a1_a2), .rd0_na3(rd0_na3), .rd0_a3(rd0_a3),
      .rd0_na4_na5(rd0_na4_na5), .rd0_na4_a5(rd0_na4_a5), .rd0_a4_na5(rd0_a4_na5), .rd0_a4_a5(rd0_a4_a5),
      .rd1_c_na0(rd1_c_na0), .rd1_c_a0(rd1_c_a0), .rd1_na1_na2(rd1_na1_na2), .rd1_na1_a2(rd1_na1_a2),
      .rd1_a1_na2(rd1_a1_na2), .rd1_a1_a2(rd1_a1_a2), .rd1_na3(rd1_na3), .rd1_a3(rd1_a3),
      .rd1_na4_na5(rd1_na4_na5), .rd1_na4_a5(rd1_na4_a5), .rd1_a4_na5(rd1_a4_na5), .rd1_a4_a5(rd1_a4_a5),
      .wr0_c_na0(wr0_c_na0), .wr0_c_a0(wr0_c_a0), .wr0_na1_na2(wr0_na1_na2), .wr0_na1_a2(wr0_na1_a2),
      .wr0_a1_na2(wr0_a1_na2), .wr0_a1_a2(wr0_a1_a2), .wr0_na3(wr0_na3), .wr0_a3(wr0_a3),
      .wr0_na4_na5(wr0_na4_na5), .wr0_na4_a5(wr0_na4_a5), .wr0_a4_na5(wr0_a4_na5), .wr0_a4_a5(wr0_a4_a5),
      .arr_wr0_dat(arr_wr0_dat), .arr_rd0_dat(arr_rd0_dat), .arr_rd1_dat(arr_rd1_dat)
   );

   logic [11:0] rd0_l, rd1_l, wr_l;
   assign rd0_l = {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
                   rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5};
   assign rd1_l = {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
                   rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5};
   assign wr_l  = {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
                   wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5};

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   // Expected 12 lines from a binary address: a0 is the address MSB.
   function automatic logic [11:0] pd(input int a, input bit en_c, input bit en_a);
      logic [11:0] v;
      int g12, g45;
      v   = '0;
      g12 = (a >> 3) & 3;
      g45 = a & 3;
      if (en_c) v[11:10] = ((a >> 5) & 1) ? 2'b01 : 2'b10;
      if (en_a) begin
         v[9:6] = 4'b1000 >> g12;
         v[5:4] = ((a >> 2) & 1) ? 2'b01 : 2'b10;
         v[3:0] = 4'b1000 >> g45;
      end
      return v;
   endfunction

   // Array decodes its own lines back to an entry index.
   function automatic logic [5:0] dec(input logic [11:0] l);
      return {l[10], l[7] | l[6], l[8] | l[6], l[4], l[1] | l[0], l[2] | l[0]};
   endfunction

   logic [0:23] mem [64];
   initial for (int i = 0; i < 64; i++) mem[i] = 24'(i * 24'h010101 + 24'h0A0B0C);

   assign arr_rd0_dat = (rd0_l[11] | rd0_l[10]) ? mem[dec(rd0_l)] : 24'h5A5A5A;
   assign arr_rd1_dat = (rd1_l[11] | rd1_l[10]) ? mem[dec(rd1_l)] : 24'hA5A5A5;
   always @(posedge clk) if (wr_l[11] | wr_l[10]) mem[dec(wr_l)] <= arr_wr0_dat;

   // Reference model: a read returns the entry contents as of its request cycle,
   // including a write accepted in that same cycle.
   logic [0:23] ref_mem [64];
   bit          known   [64];
   initial for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 24'(i * 24'h010101 + 24'h0A0B0C);
      known[i]   = 1'b1;
   end

   int          m_phase = 0;
   logic [0:5]  m_wadr  = '0;
   logic [0:23] m_wdat  = '0;
   bit          s_vld [2] = '{0, 0};
   logic [0:5]  s_adr [2];
   logic [0:23] s_dat [2];
   bit          s_kn  [2];
   bit          o_vld [2] = '{0, 0};
   logic [0:23] o_dat [2] = '{24'h0, 24'h0};
   bit          o_kn  [2] = '{1, 1};
   logic        m_acc;
   assign m_acc = wr0_req && (m_phase == 0);

   function automatic logic [0:5] radr(input int p);
      return (p == 0) ? rd0_adr : rd1_adr;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         if (m_phase >= 1 && m_phase <= WR_PULSE + 1) known[m_wadr] <= 1'b0;
         m_phase <= 0;
         for (int p = 0; p < 2; p++) begin
            s_vld[p] <= 1'b0;
            o_vld[p] <= 1'b0;
            o_dat[p] <= '0;
            o_kn[p]  <= 1'b1;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            s_vld[p] <= (p == 0) ? rd0_req : rd1_req;
            s_adr[p] <= radr(p);
            s_dat[p] <= (m_acc && wr0_adr == radr(p)) ? wr0_dat : ref_mem[radr(p)];
            s_kn[p]  <= (m_acc && wr0_adr == radr(p)) || known[radr(p)];
            o_vld[p] <= s_vld[p];
            if (s_vld[p]) begin
               o_dat[p] <= s_dat[p];
               o_kn[p]  <= s_kn[p];
            end
         end
         if (m_acc) begin
            m_phase          <= 1;
            m_wadr           <= wr0_adr;
            m_wdat           <= wr0_dat;
            ref_mem[wr0_adr] <= wr0_dat;
            known[wr0_adr]   <= 1'b1;
         end else if (m_phase == WR_PULSE + 2) m_phase <= 0;
         else if (m_phase != 0)                m_phase <= m_phase + 1;
      end
   end

   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("rd0_vld",   rd0_vld, o_vld[0]);
         check("rd1_vld",   rd1_vld, o_vld[1]);
         check("rd0_lines", rd0_l, pd(s_adr[0], s_vld[0], s_vld[0]));
         check("rd1_lines", rd1_l, pd(s_adr[1], s_vld[1], s_vld[1]));
         if (o_kn[0]) check("rd0_dat", rd0_dat_q, o_dat[0]);
         if (o_kn[1]) check("rd1_dat", rd1_dat_q, o_dat[1]);
         check("wr_lines", wr_l, pd(m_wadr, m_phase >= 2 && m_phase <= WR_PULSE + 1, m_phase != 0));
         check("wr_done",  wr0_done, m_phase == WR_PULSE + 2);
         check("wr_rdy",   wr0_rdy, m_phase == 0 && !rst);
         if (m_phase != 0) check("arr_wr_dat", arr_wr0_dat, m_wdat);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!wr0_rdy && n < 50) begin
         tick();
         n++;
      end
      check("idle_timeout", wr0_rdy, 1);
   endtask

   function automatic logic [0:5] rand_adr();
      return ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
   endfunction

   initial begin
      bit acc;
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      check("rdy_in_reset", wr0_rdy, 0);
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      @(negedge clk);
      check("idle_lines", {rd0_l, rd1_l, wr_l}, 0);
      check("idle_rdy", wr0_rdy, 1);
      check("idle_vld", {rd0_vld, rd1_vld}, 0);

      // Write 0x2A: a0=1, a1a2=01, a3=0, a4a5=10.
      tick();
      wr0_req = 1'b1; wr0_adr = 6'h2A; wr0_dat = 24'hABCDEF;
      tick();
      wr0_req = 1'b0;
      @(negedge clk);
      check("setup_lines", wr_l, 12'b0001_0010_0010);
      check("setup_arr_dat", arr_wr0_dat, 24'hABCDEF);
      tick();
      @(negedge clk);
      check("pulse1_lines", wr_l, 12'b0101_0010_0010);
      tick();
      @(negedge clk);
      check("pulse2_lines", wr_l, 12'b0101_0010_0010);
      tick();
      @(negedge clk);
      check("hold_done", wr0_done, 1);
      tick();
      @(negedge clk);
      check("rdy_back", wr0_rdy, 1);

      tick();
      rd0_req = 1'b1; rd0_adr = 6'h2A;
      rd1_req = 1'b1; rd1_adr = 6'h00;
      tick();
      rd0_req = 1'b0; rd1_req = 1'b0;
      tick();
      @(negedge clk);
      check("rd0_after_wr", {rd0_vld, rd0_dat_q}, {1'b1, 24'hABCDEF});
      check("rd1_entry0",   {rd1_vld, rd1_dat_q}, {1'b1, 24'h0A0B0C});

      // Forwarding: read issued in SETUP, accessed in the first PULSE cycle.
      tick();
      wr0_req = 1'b1; wr0_adr = 6'h15; wr0_dat = 24'h123456;
      tick();
      wr0_req = 1'b0;
      rd0_req = 1'b1; rd0_adr = 6'h15;
      rd1_req = 1'b1; rd1_adr = 6'h16;
      tick();
      rd0_req = 1'b0; rd1_req = 1'b0;
      tick();
      @(negedge clk);
      check("rd0_forward", rd0_dat_q, 24'h123456);
      check("rd1_array",   rd1_dat_q, 24'h202122);
      wait_idle();

      for (int i = 0; i < 8; i++) begin
         rd0_req = 1'b1; rd0_adr = 6'(i);
         rd1_req = 1'b1; rd1_adr = 6'(i);
         tick();
      end
      rd0_req = 1'b0; rd1_req = 1'b0;
      repeat (3) tick();

      // Reset in the first PULSE cycle, with a read in flight.
      wr0_req = 1'b1; wr0_adr = 6'h07; wr0_dat = 24'h777777;
      tick();
      wr0_req = 1'b0;
      rd0_req = 1'b1; rd0_adr = 6'h03;
      tick();
      rd0_req = 1'b0;
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("abort_lines", wr_l, 0);
      check("abort_done",  wr0_done, 0);
      check("abort_rd_vld", rd0_vld, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("abort_rdy", wr0_rdy, 1);
      check("abort_no_done", wr0_done, 0);

      for (int c = 0; c < 4000; c++) begin
         acc = wr0_req && wr0_rdy;
         tick();
         rst = ($urandom_range(0, 499) == 0);
         if (!wr0_req || acc) begin
            wr0_req = ($urandom_range(0, 2) == 0);
            wr0_adr = rand_adr();
            wr0_dat = 24'($urandom);
         end
         rd0_req = $urandom_range(0, 1);
         rd0_adr = rand_adr();
         rd1_req = $urandom_range(0, 1);
         rd1_adr = rand_adr();
      end
      rst = 1'b0; wr0_req = 1'b0; rd0_req = 1'b0; rd1_req = 1'b0;
      repeat (12) tick();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
